// File: rtl/cnn_layer_accel_pixel_fetch_engine.sv
// Pixel feeder for the CNN layer accelerator quad: answers fetch requests and streams packed
// multi-channel pixel rows from a 1-cycle-latency memory through a 2-entry bypass FIFO.
module cnn_layer_accel_pixel_fetch_engine #(
    parameter int C_PIXEL_WIDTH  = 16,
    parameter int C_NUM_CHANNELS = 8,
    parameter int C_DIM_WIDTH    = 10,
    parameter int C_ADDR_WIDTH   = 20
) (
    input  logic                                    clk_if,
    input  logic                                    rst,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    input  logic [C_DIM_WIDTH-1:0]                  num_rows_cfg,
    input  logic [C_DIM_WIDTH-1:0]                  num_cols_cfg,
    input  logic [C_DIM_WIDTH-1:0]                  rows_per_fetch_cfg,
    input  logic [C_ADDR_WIDTH-1:0]                 base_addr_cfg,
    input  logic                                    pad_en_cfg,
    input  logic                                    job_fetch_request,
    output logic                                    job_fetch_ack,
    output logic                                    job_fetch_complete,
    output logic                                    pixel_valid,
    input  logic                                    pixel_ready,
    output logic [C_PIXEL_WIDTH*C_NUM_CHANNELS-1:0] pixel_data,
    output logic                                    mem_rd_en,
    output logic [C_ADDR_WIDTH-1:0]                 mem_rd_addr,
    input  logic [C_PIXEL_WIDTH*C_NUM_CHANNELS-1:0] mem_rd_data
);
    localparam int DW = C_PIXEL_WIDTH * C_NUM_CHANNELS;
    localparam int RW = C_DIM_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_REQ, S_ACK, S_STREAM, S_COMPLETE, S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [C_DIM_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d, rpf_q, rpf_d;
    logic                    pad_q, pad_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RW-1:0]           cur_row_q, cur_row_d, beat_q, beat_d;
    logic [C_DIM_WIDTH-1:0]  fetch_row_q, fetch_row_d;
    logic                    issue_done_q, issue_done_d;
    // Stage A: issued, read strobe on the bus. Stage B: data on mem_rd_data (or a pad zero).
    logic                    a_valid_q, a_valid_d, a_pad_q, a_pad_d;
    logic                    b_valid_q, b_valid_d, b_pad_q, b_pad_d;
    logic [DW-1:0]           fifo_mem_q [2];
    logic [DW-1:0]           fifo_mem_d [2];
    logic                    fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;
    logic                    mem_rd_en_q, mem_rd_en_d;
    logic [C_ADDR_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic                    busy_q, busy_d, done_q, done_d, ack_q, ack_d, complete_q, complete_d;

    logic                    fifo_nonempty, pop, push, fifo_pop, room, issuing, pad_beat, pad_direct, last_row;
    logic [2:0]              outstanding;
    logic [RW-1:0]           row_last;
    logic [DW-1:0]           b_data;

    assign fifo_nonempty = (fifo_cnt_q != 2'd0);
    assign b_data        = b_pad_q ? '0 : mem_rd_data;
    assign pixel_valid   = fifo_nonempty || b_valid_q;
    assign pixel_data    = fifo_nonempty ? fifo_mem_q[fifo_rd_q] : (b_valid_q ? b_data : '0);
    assign pop           = pixel_valid && pixel_ready;
    assign push          = b_valid_q && !(!fifo_nonempty && pop);
    assign fifo_pop      = pop && fifo_nonempty;
    assign outstanding   = {2'b00, a_valid_q} + {2'b00, b_valid_q} + {1'b0, fifo_cnt_q};
    // Count the beat leaving this cycle as already gone so ready-high streaming has no bubbles.
    assign room          = (outstanding - {2'b00, pop}) < 3'd2;
    assign row_last      = pad_q ? ({1'b0, cols_q} + RW'(2)) : {1'b0, cols_q};
    assign pad_beat      = pad_q && ((beat_q == '0) || (beat_q == row_last));
    assign last_row      = (fetch_row_q == rpf_q) || (cur_row_q == {1'b0, rows_q});
    assign issuing       = ((state_q == S_ACK) || (state_q == S_STREAM)) && !issue_done_q && room;
    // A pad may skip stage A only when nothing sits there, otherwise it would overtake a read.
    assign pad_direct    = issuing && pad_beat && !a_valid_q;

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        rpf_d        = rpf_q;
        pad_d        = pad_q;
        addr_d       = addr_q;
        cur_row_d    = cur_row_q;
        beat_d       = beat_q;
        fetch_row_d  = fetch_row_q;
        issue_done_d = issue_done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_WAIT_REQ;
                    rows_d       = num_rows_cfg;
                    cols_d       = num_cols_cfg;
                    rpf_d        = rows_per_fetch_cfg;
                    pad_d        = pad_en_cfg;
                    addr_d       = base_addr_cfg;
                    cur_row_d    = '0;
                    beat_d       = '0;
                    fetch_row_d  = '0;
                    issue_done_d = 1'b0;
                end
            end
            S_WAIT_REQ: if (job_fetch_request) state_d = S_ACK;
            S_ACK:      state_d = S_STREAM;
            S_STREAM:   if (issue_done_q && (outstanding == 3'd1) && pop) state_d = S_COMPLETE;
            S_COMPLETE: begin
                issue_done_d = 1'b0;
                state_d      = (cur_row_q <= {1'b0, rows_q}) ? S_WAIT_REQ : S_FINISH;
            end
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (issuing) begin
            if (!pad_beat) addr_d = addr_q + C_ADDR_WIDTH'(1);
            if (beat_q == row_last) begin
                beat_d    = '0;
                cur_row_d = cur_row_q + RW'(1);
                if (last_row) begin
                    fetch_row_d  = '0;
                    issue_done_d = 1'b1;
                end else begin
                    fetch_row_d = fetch_row_q + C_DIM_WIDTH'(1);
                end
            end else begin
                beat_d = beat_q + RW'(1);
            end
        end

        a_valid_d     = issuing && !pad_direct;
        a_pad_d       = issuing && pad_beat;
        b_valid_d     = a_valid_q || pad_direct;
        b_pad_d       = a_valid_q ? a_pad_q : 1'b1;
        mem_rd_en_d   = issuing && !pad_beat;
        mem_rd_addr_d = mem_rd_en_d ? addr_q : mem_rd_addr_q;

        fifo_wr_d = fifo_wr_q ^ push;
        fifo_rd_d = fifo_rd_q ^ fifo_pop;
        case ({push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        for (int i = 0; i < 2; i++) begin
            fifo_mem_d[i] = (push && (fifo_wr_q == i[0])) ? b_data : fifo_mem_q[i];
        end

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FINISH);
        ack_d      = (state_d == S_ACK);
        complete_d = (state_d == S_COMPLETE);
    end

    always_ff @(posedge clk_if) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rows_q        <= '0;
            cols_q        <= '0;
            rpf_q         <= '0;
            pad_q         <= 1'b0;
            addr_q        <= '0;
            cur_row_q     <= '0;
            beat_q        <= '0;
            fetch_row_q   <= '0;
            issue_done_q  <= 1'b0;
            a_valid_q     <= 1'b0;
            a_pad_q       <= 1'b0;
            b_valid_q     <= 1'b0;
            b_pad_q       <= 1'b0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ack_q         <= 1'b0;
            complete_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            rpf_q         <= rpf_d;
            pad_q         <= pad_d;
            addr_q        <= addr_d;
            cur_row_q     <= cur_row_d;
            beat_q        <= beat_d;
            fetch_row_q   <= fetch_row_d;
            issue_done_q  <= issue_done_d;
            a_valid_q     <= a_valid_d;
            a_pad_q       <= a_pad_d;
            b_valid_q     <= b_valid_d;
            b_pad_q       <= b_pad_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
            for (int i = 0; i < 2; i++) fifo_mem_q[i] <= fifo_mem_d[i];
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ack_q         <= ack_d;
            complete_q    <= complete_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign job_fetch_ack      = ack_q;
    assign job_fetch_complete = complete_q;
    assign mem_rd_en          = mem_rd_en_q;
    assign mem_rd_addr        = mem_rd_addr_q;
endmodule

// File: tb/tb_cnn_layer_accel_pixel_fetch_engine.sv
// Bench for the pixel fetch engine: layer table plus random layers against an arithmetic
// row-major reference, with hand sequences for mid-layer reset and ignored start/request.
module tb_cnn_layer_accel_pixel_fetch_engine;
    localparam int PW = 16, NC = 8, DIMW = 10, AW = 20, DW = PW * NC;

    logic            clk_if = 1'b0, rst = 1'b1, start = 1'b0;
    logic            busy, done;
    logic [DIMW-1:0] num_rows_cfg = '0, num_cols_cfg = '0, rows_per_fetch_cfg = '0;
    logic [AW-1:0]   base_addr_cfg = '0;
    logic            pad_en_cfg = 1'b0;
    logic            job_fetch_request = 1'b0, job_fetch_ack, job_fetch_complete;
    logic            pixel_valid, pixel_ready = 1'b0;
    logic [DW-1:0]   pixel_data;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_rd_addr;
    logic [DW-1:0]   mem_rd_data = '0;
    logic [DW-1:0]   mem_arr [4096];
    int              errors = 0, checks = 0;

    typedef struct {
        int rows; int cols; int rpf; int base;
        bit pad; bit rnd_ready; bit poke;
        int exp_fetches; int exp_beats;
    } layer_t;
    layer_t tbl [8];

    cnn_layer_accel_pixel_fetch_engine #(
        .C_PIXEL_WIDTH(PW), .C_NUM_CHANNELS(NC), .C_DIM_WIDTH(DIMW), .C_ADDR_WIDTH(AW)
    ) dut (
        .clk_if(clk_if), .rst(rst), .start(start), .busy(busy), .done(done),
        .num_rows_cfg(num_rows_cfg), .num_cols_cfg(num_cols_cfg),
        .rows_per_fetch_cfg(rows_per_fetch_cfg), .base_addr_cfg(base_addr_cfg),
        .pad_en_cfg(pad_en_cfg), .job_fetch_request(job_fetch_request),
        .job_fetch_ack(job_fetch_ack), .job_fetch_complete(job_fetch_complete),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    always #5 clk_if = ~clk_if;

    always @(posedge clk_if) if (mem_rd_en) mem_rd_data <= mem_arr[mem_rd_addr[11:0]];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_at(input int a);
        logic [AW-1:0] w;
        w = a[AW-1:0];
        return mem_arr[w[11:0]];
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ack"}, job_fetch_ack, 0);
        chk({tag, "_complete"}, job_fetch_complete, 0);
        chk({tag, "_valid"}, pixel_valid, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_data"}, pixel_data, 0);
        chk({tag, "_rd_addr"}, mem_rd_addr, 0);
    endtask

    task automatic run_layer(input layer_t L);
        logic [DW-1:0] exp_q [$];
        int            fsize_q [$];
        int            r, nf, bpr, cyc, ack_cyc, first_cyc, last_acc_cyc, fbeats;
        int            acks, compls, dones, accepted, reads, cur_size;
        bit            in_fetch, seen_valid, prev_stall, finished, poked;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] exp_addr;

        bpr = L.cols + 1 + (L.pad ? 2 : 0);
        r = 0;
        while (r <= L.rows) begin
            nf = (L.rpf + 1 < L.rows + 1 - r) ? L.rpf + 1 : L.rows + 1 - r;
            fsize_q.push_back(nf * bpr);
            for (int i = 0; i < nf; i++) begin
                if (L.pad) exp_q.push_back('0);
                for (int c = 0; c <= L.cols; c++) exp_q.push_back(mem_at(L.base + (r + i) * (L.cols + 1) + c));
                if (L.pad) exp_q.push_back('0);
            end
            r += nf;
        end

        num_rows_cfg       = L.rows[DIMW-1:0];
        num_cols_cfg       = L.cols[DIMW-1:0];
        rows_per_fetch_cfg = L.rpf[DIMW-1:0];
        base_addr_cfg      = L.base[AW-1:0];
        pad_en_cfg         = L.pad;
        job_fetch_request  = 1'b1;
        pixel_ready        = 1'b1;
        start              = 1'b1;
        @(negedge clk_if);
        start = 1'b0;

        cyc = 0; ack_cyc = 0; first_cyc = 0; last_acc_cyc = 0; fbeats = 0;
        acks = 0; compls = 0; dones = 0; accepted = 0; reads = 0;
        in_fetch = 0; seen_valid = 0; prev_stall = 0; finished = 0; poked = 0;
        prev_data = '0;
        exp_addr = L.base[AW-1:0];

        while (!finished && cyc < 6000) begin
            start = 1'b0;
            pixel_ready = L.rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            chk("busy_run", busy, 1);
            if (prev_stall) begin
                chk("hold_valid", pixel_valid, 1);
                chk("hold_data", pixel_data, prev_data);
            end
            if (job_fetch_ack) begin
                acks++; ack_cyc = cyc; seen_valid = 0; fbeats = 0; in_fetch = 1;
                chk("valid_at_ack", pixel_valid, 0);
            end
            if (mem_rd_en) begin
                chk("rd_addr", mem_rd_addr, exp_addr);
                exp_addr = exp_addr + 1'b1;
                reads++;
            end
            if (pixel_valid) begin
                chk("valid_in_fetch", in_fetch, 1);
                if (!seen_valid) begin
                    seen_valid = 1; first_cyc = cyc;
                    chk("first_valid_lat", cyc - ack_cyc, L.pad ? 1 : 2);
                end
                if (pixel_ready) begin
                    accepted++; fbeats++; last_acc_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_beat: got 0x%0h with no beat expected", pixel_data);
                    end else begin
                        chk("beat_data", pixel_data, exp_q.pop_front());
                    end
                end
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_data  = pixel_data;
            if (job_fetch_complete) begin
                compls++; in_fetch = 0;
                cur_size = (fsize_q.size() != 0) ? fsize_q.pop_front() : -1;
                chk("fetch_beats", fbeats, cur_size);
                if (!L.rnd_ready && !L.pad) chk("zero_bubble", last_acc_cyc - first_cyc + 1, cur_size);
                $display("fetch %0d: %0d beats (rows %0d cols %0d rpf %0d pad %0d)",
                         compls, fbeats, L.rows + 1, L.cols + 1, L.rpf + 1, L.pad);
            end
            if (done) begin
                dones++; finished = 1;
            end
            if (L.poke && !poked && accepted == 3) begin
                poked = 1; start = 1'b1;
                num_rows_cfg = '1; num_cols_cfg = '1; rows_per_fetch_cfg = '0;
                base_addr_cfg = '0; pad_en_cfg = 1'b1;
            end
            @(negedge clk_if);
            cyc++;
        end
        start = 1'b0;
        job_fetch_request = 1'b0;
        if (!finished) begin
            checks++; errors++;
            $display("FAIL layer_timeout: got no done after %0d cycles", cyc);
        end
        chk("ack_count", acks, L.exp_fetches);
        chk("complete_count", compls, L.exp_fetches);
        chk("done_count", dones, 1);
        chk("accepted_beats", accepted, L.exp_beats);
        chk("leftover_beats", exp_q.size(), 0);
        chk("mem_reads", reads, (L.rows + 1) * (L.cols + 1));
        chk("busy_after_done", busy, 0);
        chk("valid_after_done", pixel_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        layer_t L;
        int     cnt, cyc;

        for (int i = 0; i < 4096; i++) mem_arr[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        tbl[0] = '{9, 9, 0, 0,       0, 0, 0, 10, 100};
        tbl[1] = '{9, 9, 3, 0,       0, 0, 0, 3,  100};
        tbl[2] = '{3, 3, 0, 'h100,   1, 0, 0, 4,  24};
        tbl[3] = '{9, 9, 0, 0,       0, 1, 0, 10, 100};
        tbl[4] = '{2, 4, 1, 'hFFFFC, 1, 1, 0, 2,  21};
        tbl[5] = '{0, 0, 0, 5,       0, 0, 0, 1,  1};
        tbl[6] = '{4, 2, 9, 'h40,    0, 1, 1, 1,  15};
        tbl[7] = '{9, 9, 0, 'h20,    0, 0, 0, 10, 100};

        repeat (3) @(negedge clk_if);
        check_outputs_zero("reset");
        rst = 1'b0;

        // A request held while idle must not be acked and must not make the block busy.
        job_fetch_request = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_if);
            chk("idle_req_ack", job_fetch_ack, 0);
            chk("idle_req_busy", busy, 0);
        end
        job_fetch_request = 1'b0;

        for (int t = 0; t < 7; t++) run_layer(tbl[t]);

        // Reset after five accepted beats of the first fetch, then restream from base.
        L = tbl[7];
        num_rows_cfg = L.rows[DIMW-1:0]; num_cols_cfg = L.cols[DIMW-1:0];
        rows_per_fetch_cfg = L.rpf[DIMW-1:0]; base_addr_cfg = L.base[AW-1:0]; pad_en_cfg = 1'b0;
        job_fetch_request = 1'b1; pixel_ready = 1'b1; start = 1'b1;
        @(negedge clk_if);
        start = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 5 && cyc < 200) begin
            if (pixel_valid && pixel_ready) cnt++;
            if (cnt < 5) begin
                @(negedge clk_if);
                cyc++;
            end
        end
        chk("pre_reset_beats", cnt, 5);
        @(negedge clk_if);
        rst = 1'b1;
        @(negedge clk_if);
        rst = 1'b0;
        check_outputs_zero("midreset");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_if);
            chk("post_reset_ack", job_fetch_ack, 0);
            chk("post_reset_complete", job_fetch_complete, 0);
            chk("post_reset_done", done, 0);
        end
        job_fetch_request = 1'b0;
        run_layer(tbl[7]);

        for (int t = 0; t < 3; t++) begin
            L.rows = $urandom_range(0, 5);
            L.cols = $urandom_range(0, 6);
            L.rpf = $urandom_range(0, 3);
            L.base = $urandom_range(0, (1 << AW) - 1);
            L.pad = $urandom_range(0, 1);
            L.rnd_ready = 1;
            L.poke = 0;
            L.exp_fetches = (L.rows + 1 + L.rpf) / (L.rpf + 1);
            L.exp_beats = (L.rows + 1) * (L.cols + 1 + (L.pad ? 2 : 0));
            run_layer(L);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cnn_layer_accel_pixel_fetch_engine.md
Name: cnn_layer_accel_pixel_fetch_engine

Overview:
- Synthesizable replacement for the bench-side pixel feeder of the CNN layer accelerator quad; runs in the interface clock domain.
- Answers the quad's job_fetch_request with a fetch-ack / stream / fetch-complete sequence.
- Reads packed multi-channel pixel words from a 1-cycle-latency memory and drives pixel_valid/pixel_data under pixel_ready backpressure.
- Generalised over pixel width, channel count, rows per fetch, base address, and an optional zero-padding mode.

Parameters:
C_PIXEL_WIDTH, 16, bits per pixel per channel
C_NUM_CHANNELS, 8, channels packed per beat; channel 0 in LSBs
C_DIM_WIDTH, 10, width of row/col config fields
C_ADDR_WIDTH, 20, memory word address width

Ports:
clk_if  in  1  interface clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a layer; sampled only in IDLE
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of layer
num_rows_cfg  in  C_DIM_WIDTH  rows minus one
num_cols_cfg  in  C_DIM_WIDTH  cols minus one
rows_per_fetch_cfg  in  C_DIM_WIDTH  rows per fetch, minus one
base_addr_cfg  in  C_ADDR_WIDTH  word address of pixel (0,0)
pad_en_cfg  in  1  insert a zero beat before and after every row
job_fetch_request  in  1  level request from quad
job_fetch_ack  out  1  one-cycle pulse
job_fetch_complete  out  1  one-cycle pulse after last beat of a fetch
pixel_valid  out  1  beat valid
pixel_ready  in  1  beat accepted when valid&&ready
pixel_data  out  C_PIXEL_WIDTH*C_NUM_CHANNELS  packed beat
mem_rd_en  out  1  read strobe
mem_rd_addr  out  C_ADDR_WIDTH  word address
mem_rd_data  in  C_PIXEL_WIDTH*C_NUM_CHANNELS  data, valid exactly 1 cycle after mem_rd_en

Behaviour:
- Reset: state IDLE; busy, done, job_fetch_ack, job_fetch_complete, pixel_valid, mem_rd_en all 0; pixel_data, mem_rd_addr 0; output FIFO and counters cleared. A reset mid-operation aborts the layer immediately with no complete or done pulse; an in-flight read return is discarded.
- Config is latched on start in IDLE. Config inputs are ignored at all other times.
- start while busy: ignored.
- States:
  - IDLE: start -> WAIT_REQ.
  - WAIT_REQ: job_fetch_request=1 -> ACK. A request seen in IDLE is never acked.
  - ACK: job_fetch_ack=1 for exactly this cycle -> STREAM.
  - STREAM: emits min(rows_per_fetch, rows_remaining) rows. Each row is cols beats, or cols+2 beats with pad_en (first and last beats all-zero; no memory read for them). When the last beat of the fetch is accepted -> COMPLETE.
  - COMPLETE: job_fetch_complete=1 for one cycle. Rows remain -> WAIT_REQ; otherwise -> FINISH.
  - FINISH: done=1 for one cycle -> IDLE.
- Addressing:
  - Row-major, mem_rd_addr = base + row*(cols) + col.
  - Generated by increment only, no multiplier; wraps modulo 2^C_ADDR_WIDTH.
  - The address counter persists across fetches.
- Buffering:
  - 2-entry output FIFO drives pixel_valid/pixel_data.
  - A read (or pad-zero insert) issues only when FIFO occupancy + in-flight < 2.
  - Zero-bubble throughput at 1 beat/cycle with ready held high.
- Latency: first mem_rd_en is the cycle after ACK. The first pixel_valid is 2 cycles after the ACK cycle (pad-zero beat: 1 cycle after).
- Handshake: pixel_data and pixel_valid are held stable while valid&&!ready. pixel_valid is never high outside STREAM.
- No reads are issued beyond the fetch's final beat.

Test Plan:
1. 10x10 layer, 8 ch, rows_per_fetch=0, ready=1, base=0 -> 10 ack/complete pairs, each fetch 10 beats matching mem[0..99] in order; one done pulse; pixel_valid high 10 consecutive cycles per fetch, first 2 cycles after ack.
2. num_rows=9, rows_per_fetch=3 -> fetches of 4, 4, 2 rows (40, 40, 20 beats); mem_rd_addr continues 40, 80 across fetches; done after third complete.
3. 4x4, pad_en=1, base=0x100 -> 6 beats per row: 0, mem[0x100..0x103], 0; 4 fetches of 6 beats each; no mem_rd_en for pad beats.
4. 10x10, pixel_ready random 50% -> exactly 100 accepted beats, no duplicate or drop; pixel_data unchanged on every valid&&!ready cycle.
5. rst after 5 accepted beats of fetch 1 -> all outputs 0 next cycle, no complete or done pulse; new start restreams from address base.
6. start pulsed during STREAM and request held in IDLE -> no config change, no ack until start; busy tracks state.
